// File: rtl/epmp_bus_arbiter_if.sv
// EPMP bus arbiter signal bundle.
//   Requester side : CPU_* / DMA_* request, direction, address, write data; Din/Ack returns.
//   Memory side    : A, D_In, D_Out, D_Oe, Read, Write.
//   Debug          : Debug_Arb_State (IDLE=0 SETUP=1 ACCESS=2 DONE=3), Debug_Grant {dma, cpu}.
// Modport slave is the arbiter's view; modport master is the view of whoever drives it.
interface epmp_bus_arbiter_if;
   logic        CPU_Req;
   logic        CPU_Write;
   logic [15:0] CPU_A;
   logic [7:0]  CPU_Dout;
   logic [7:0]  CPU_Din;
   logic        CPU_Ack;
   logic        DMA_Req;
   logic        DMA_Write;
   logic [15:0] DMA_A;
   logic [7:0]  DMA_Dout;
   logic [7:0]  DMA_Din;
   logic        DMA_Ack;
   logic [15:0] A;
   logic [7:0]  D_In;
   logic [7:0]  D_Out;
   logic        D_Oe;
   logic        Read;
   logic        Write;
   logic [1:0]  Debug_Arb_State;
   logic [1:0]  Debug_Grant;

   modport slave (
      input  CPU_Req, CPU_Write, CPU_A, CPU_Dout,
      input  DMA_Req, DMA_Write, DMA_A, DMA_Dout,
      input  D_In,
      output CPU_Din, CPU_Ack, DMA_Din, DMA_Ack,
      output A, D_Out, D_Oe, Read, Write,
      output Debug_Arb_State, Debug_Grant
   );

   modport master (
      output CPU_Req, CPU_Write, CPU_A, CPU_Dout,
      output DMA_Req, DMA_Write, DMA_A, DMA_Dout,
      output D_In,
      input  CPU_Din, CPU_Ack, DMA_Din, DMA_Ack,
      input  A, D_Out, D_Oe, Read, Write,
      input  Debug_Arb_State, Debug_Grant
   );
endinterface

// File: rtl/epmp_bus_arbiter.sv
// EPMP external memory bus sequencer shared between a CPU port and a DMA/debug port.
// Each transfer runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE, then back to IDLE.
// Requests are sampled only in IDLE; ties go round-robin (CPU wins the first tie after reset).
// Defining EPMP_ARB_DMA_PRIO_EN switches ties to fixed DMA priority.
// Ports:
//   clk   - system clock
//   Reset - synchronous, active-high reset
//   bus   - epmp_bus_arbiter_if.slave: requester ports, memory pad signals, debug state/grant
module epmp_bus_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              Reset,
   epmp_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSetup  = 2'd1,
      StAccess = 2'd2,
      StDone   = 2'd3
   } arb_state_e;

   localparam logic [3:0] WaitInit = WAIT_CYCLES[3:0];

   arb_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_dma_q, owner_dma_d;
   logic        is_write_q, is_write_d;
   logic        last_dma_q, last_dma_d;
   logic [15:0] a_q, a_d;
   logic [7:0]  dout_q, dout_d;
   logic        doe_q, doe_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        dma_ack_q, dma_ack_d;
   logic [7:0]  cpu_din_q, cpu_din_d;
   logic [7:0]  dma_din_q, dma_din_d;

   logic        pick_dma;
   logic        sel_write;
   logic [15:0] sel_a;
   logic [7:0]  sel_dout;

`ifdef EPMP_ARB_DMA_PRIO_EN
   assign pick_dma = bus.DMA_Req;
`else
   // DMA wins only if alone, or if it lost the previous arbitration.
   assign pick_dma = bus.DMA_Req && (!bus.CPU_Req || !last_dma_q);
`endif
   assign sel_write = pick_dma ? bus.DMA_Write : bus.CPU_Write;
   assign sel_a     = pick_dma ? bus.DMA_A     : bus.CPU_A;
   assign sel_dout  = pick_dma ? bus.DMA_Dout  : bus.CPU_Dout;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_dma_d = owner_dma_q;
      is_write_d  = is_write_q;
      last_dma_d  = last_dma_q;
      a_d         = a_q;
      dout_d      = dout_q;
      doe_d       = doe_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      cpu_din_d   = cpu_din_q;
      dma_din_d   = dma_din_q;
      unique case (state_q)
         StIdle: begin
            if (bus.CPU_Req || bus.DMA_Req) begin
               owner_dma_d = pick_dma;
               is_write_d  = sel_write;
               a_d         = sel_a;
               if (sel_write) begin
                  dout_d = sel_dout;
                  doe_d  = 1'b1;
               end
               state_d = StSetup;
            end
         end
         StSetup: begin
            rd_d    = !is_write_q;
            wr_d    = is_write_q;
            cnt_d   = WaitInit;
            state_d = StAccess;
         end
         StAccess: begin
            if (cnt_q == 4'd0) begin
               rd_d  = 1'b0;
               wr_d  = 1'b0;
               doe_d = 1'b0;
               if (!is_write_q) begin
                  if (owner_dma_q) dma_din_d = bus.D_In;
                  else             cpu_din_d = bus.D_In;
               end
               // Registered so the pulse lines up exactly with DONE.
               if (owner_dma_q) dma_ack_d = 1'b1;
               else             cpu_ack_d = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            last_dma_d = owner_dma_q;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         owner_dma_q <= 1'b0;
         is_write_q  <= 1'b0;
         last_dma_q  <= 1'b1;
         a_q         <= '0;
         dout_q      <= '0;
         doe_q       <= 1'b0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_din_q   <= '0;
         dma_din_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_dma_q <= owner_dma_d;
         is_write_q  <= is_write_d;
         last_dma_q  <= last_dma_d;
         a_q         <= a_d;
         dout_q      <= dout_d;
         doe_q       <= doe_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         cpu_din_q   <= cpu_din_d;
         dma_din_q   <= dma_din_d;
      end
   end

   assign bus.A               = a_q;
   assign bus.D_Out           = dout_q;
   assign bus.D_Oe            = doe_q;
   assign bus.Read            = rd_q;
   assign bus.Write           = wr_q;
   assign bus.CPU_Ack         = cpu_ack_q;
   assign bus.DMA_Ack         = dma_ack_q;
   assign bus.CPU_Din         = cpu_din_q;
   assign bus.DMA_Din         = dma_din_q;
   assign bus.Debug_Arb_State = state_q;
   assign bus.Debug_Grant     = (state_q == StIdle) ? 2'b00 : {owner_dma_q, !owner_dma_q};

endmodule

// File: tb/tb_epmp_bus_arbiter.sv
module tb_epmp_bus_arbiter;
   localparam int W = 1;

   typedef struct {
      bit          dma;
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [7:0]  rdata;
      int          ack_edge;
   } txn_t;

   logic clk = 1'b0;
   logic Reset;
   always #5 clk = ~clk;

   epmp_bus_arbiter_if bus ();
   epmp_bus_arbiter_if bus0 ();

   epmp_bus_arbiter #(.WAIT_CYCLES(W)) dut (.clk(clk), .Reset(Reset), .bus(bus));
   epmp_bus_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .Reset(Reset), .bus(bus0));

   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   int   strobe_cnt = 0;
   txn_t sb[$];
   logic [7:0] m_cpu_din, m_dma_din;
   logic       fix_en;
   logic [7:0] fix_val;

   // Memory contents seen on the pad: a fixed function of the address.
   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[15:8] ^ a[7:0] ^ 8'h5A;
   endfunction

   assign bus.D_In  = fix_en ? fix_val : mem_f(bus.A);
   assign bus0.D_In = mem_f(bus0.A);

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic set_port(input bit dma, input bit req, input bit wr, input logic [15:0] a,
                           input logic [7:0] d);
      if (dma) begin
         bus.DMA_Req = req; bus.DMA_Write = wr; bus.DMA_A = a; bus.DMA_Dout = d;
      end else begin
         bus.CPU_Req = req; bus.CPU_Write = wr; bus.CPU_A = a; bus.CPU_Dout = d;
      end
   endtask

   task automatic drop_req(input bit dma);
      if (dma) bus.DMA_Req = 1'b0;
      else     bus.CPU_Req = 1'b0;
   endtask

   function automatic bit own_ack(input bit dma);
      return dma ? bus.DMA_Ack : bus.CPU_Ack;
   endfunction

   // Wait (bounded) for this port's Ack; optionally drop Req once the port owns the bus.
   task automatic wait_ack(input bit dma, input bit allow_drop);
      bit seen = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (own_ack(dma)) seen = 1;
         else if (allow_drop && bus.Debug_Grant == (dma ? 2'b10 : 2'b01)
                  && $urandom_range(0, 3) == 0) drop_req(dma);
      end
      chk(dma ? "dma_ack_timeout" : "cpu_ack_timeout", 32'(seen), 32'd1);
   endtask

   task automatic rand_port(input bit dma, input int n);
      bit hold = 0;
      for (int i = 0; i < n; i++) begin
         if (!hold) repeat ($urandom_range(1, 4)) @(negedge clk);
         set_port(dma, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
         wait_ack(dma, 1'b1);
         hold = ($urandom_range(0, 3) == 0);
         if (!hold) drop_req(dma);
      end
      drop_req(dma);
   endtask

   // Reference model: a transfer occupies the bus for W+3 cycles after its grant,
   // and the Ack lands W+2 edges after the granting edge.
   initial begin : model
      int   busy;
      bit   last_dma;
      bit   take_dma;
      txn_t t;
      busy = 0;
      last_dma = 1;
      forever begin
         @(posedge clk);
         edge_cnt++;
         if (Reset) begin
            sb.delete();
            busy = 0;
            last_dma = 1;
            m_cpu_din = 8'h00;
            m_dma_din = 8'h00;
            strobe_cnt = 0;
         end else if (busy > 0) begin
            busy--;
         end else if (bus.CPU_Req || bus.DMA_Req) begin
`ifdef EPMP_ARB_DMA_PRIO_EN
            take_dma = bus.DMA_Req;
`else
            if (bus.CPU_Req && bus.DMA_Req) take_dma = !last_dma;
            else                            take_dma = bus.DMA_Req;
`endif
            t.dma      = take_dma;
            t.wr       = take_dma ? bus.DMA_Write : bus.CPU_Write;
            t.addr     = take_dma ? bus.DMA_A : bus.CPU_A;
            t.data     = take_dma ? bus.DMA_Dout : bus.CPU_Dout;
            t.rdata    = fix_en ? fix_val : mem_f(t.addr);
            t.ack_edge = edge_cnt + W + 2;
            sb.push_back(t);
            last_dma = take_dma;
            busy = W + 3;
         end
      end
   end

   initial begin : monitor
      txn_t t;
      logic [1:0] st;
      forever begin
         @(negedge clk);
         st = bus.Debug_Arb_State;
         chk("rd_wr_excl", 32'(bus.Read & bus.Write), 32'd0);
         chk("oe_phase", 32'(bus.D_Oe && !(st == 2'd1 || st == 2'd2)), 32'd0);
         chk("oe_on_read", 32'(bus.D_Oe & bus.Read), 32'd0);
         chk("strobe_phase", 32'((bus.Read || bus.Write) && (st == 2'd0 || st == 2'd1)), 32'd0);
         chk("cpu_ack_owner", 32'(bus.CPU_Ack && !(st == 2'd3 && bus.Debug_Grant == 2'b01)), 32'd0);
         chk("dma_ack_owner", 32'(bus.DMA_Ack && !(st == 2'd3 && bus.Debug_Grant == 2'b10)), 32'd0);
         if (sb.size() == 0) begin
            chk("strobe_no_txn", 32'(bus.Read | bus.Write), 32'd0);
         end else if (bus.Read || bus.Write) begin
            t = sb[0];
            strobe_cnt++;
            chk("acc_addr", 32'(bus.A), 32'(t.addr));
            chk("acc_dir", 32'(bus.Write), 32'(t.wr));
            chk("acc_grant", 32'(bus.Debug_Grant), t.dma ? 32'd2 : 32'd1);
            chk("acc_oe", 32'(bus.D_Oe), 32'(t.wr));
            if (t.wr) chk("acc_dout", 32'(bus.D_Out), 32'(t.data));
         end
         if (bus.CPU_Ack || bus.DMA_Ack) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'({bus.DMA_Ack, bus.CPU_Ack}), 32'd0);
            end else begin
               t = sb.pop_front();
               chk("ack_who", 32'({bus.DMA_Ack, bus.CPU_Ack}), t.dma ? 32'd2 : 32'd1);
               chk("ack_edge", 32'(edge_cnt), 32'(t.ack_edge));
               chk("strobe_cycles", 32'(strobe_cnt), 32'(W + 1));
               strobe_cnt = 0;
               if (!t.wr) begin
                  if (t.dma) m_dma_din = t.rdata;
                  else       m_cpu_din = t.rdata;
               end
               chk("cpu_din", 32'(bus.CPU_Din), 32'(m_cpu_din));
               chk("dma_din", 32'(bus.DMA_Din), 32'(m_dma_din));
            end
         end
      end
   end

   initial begin : stim
      bit order[4];
      bit exp_order[4];
      int k;
      int e;
      int n_ack;
      int n_rd;
      int ack_e;
      bit found;
      Reset = 1'b1;
      fix_en = 1'b0;
      fix_val = 8'h00;
      set_port(0, 0, 0, 16'h0, 8'h0);
      set_port(1, 0, 0, 16'h0, 8'h0);
      bus0.CPU_Req = 0; bus0.CPU_Write = 0; bus0.CPU_A = 0; bus0.CPU_Dout = 0;
      bus0.DMA_Req = 0; bus0.DMA_Write = 0; bus0.DMA_A = 0; bus0.DMA_Dout = 0;
      repeat (3) @(negedge clk);

      chk("rst_A", 32'(bus.A), 32'd0);
      chk("rst_D_Out", 32'(bus.D_Out), 32'd0);
      chk("rst_D_Oe", 32'(bus.D_Oe), 32'd0);
      chk("rst_Read", 32'(bus.Read), 32'd0);
      chk("rst_Write", 32'(bus.Write), 32'd0);
      chk("rst_acks", 32'({bus.DMA_Ack, bus.CPU_Ack}), 32'd0);
      chk("rst_CPU_Din", 32'(bus.CPU_Din), 32'd0);
      chk("rst_DMA_Din", 32'(bus.DMA_Din), 32'd0);
      chk("rst_state", 32'(bus.Debug_Arb_State), 32'd0);
      chk("rst_grant", 32'(bus.Debug_Grant), 32'd0);
      Reset = 1'b0;

      // CPU read with a fixed pad value.
      fix_en = 1'b1;
      fix_val = 8'hA5;
      set_port(0, 1, 0, 16'h1234, 8'h00);
      wait_ack(0, 1'b0);
      drop_req(0);
      chk("t1_cpu_din", 32'(bus.CPU_Din), 32'hA5);
      fix_en = 1'b0;

      // DMA write.
      set_port(1, 1, 1, 16'hFFFF, 8'h3C);
      wait_ack(1, 1'b0);
      drop_req(1);
      chk("t2_cpu_din_kept", 32'(bus.CPU_Din), 32'hA5);

      // Four tied transfers.
      @(negedge clk);
      set_port(0, 1, 0, 16'h0100, 8'h11);
      set_port(1, 1, 1, 16'h0200, 8'h22);
      k = 0;
      for (int c = 0; c < 80 && k < 4; c++) begin
         @(negedge clk);
         if (bus.CPU_Ack || bus.DMA_Ack) begin
            order[k] = bus.DMA_Ack;
            k++;
         end
      end
      drop_req(0);
      drop_req(1);
      chk("t3_ack_count", 32'(k), 32'd4);
`ifdef EPMP_ARB_DMA_PRIO_EN
      exp_order = '{1, 1, 1, 1};
`else
      exp_order = '{0, 1, 0, 1};
`endif
      for (int i = 0; i < 4; i++) chk("t3_order", 32'(order[i]), 32'(exp_order[i]));

      // Reset during ACCESS of a CPU write.
      @(negedge clk);
      set_port(0, 1, 1, 16'h0BAD, 8'h77);
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (bus.Debug_Arb_State == 2'd2) found = 1;
      end
      chk("t4_reach_access", 32'(found), 32'd1);
      Reset = 1'b1;
      drop_req(0);
      @(negedge clk);
      chk("t4_strobes", 32'({bus.Read, bus.Write, bus.D_Oe}), 32'd0);
      chk("t4_acks", 32'({bus.DMA_Ack, bus.CPU_Ack}), 32'd0);
      chk("t4_state", 32'(bus.Debug_Arb_State), 32'd0);
      Reset = 1'b0;
      n_ack = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.CPU_Ack) n_ack++;
      end
      chk("t4_no_ack", 32'(n_ack), 32'd0);

      // Zero wait states; Req dropped during SETUP.
      e = edge_cnt;
      bus0.CPU_Req = 1'b1;
      bus0.CPU_Write = 1'b0;
      bus0.CPU_A = 16'h0042;
      @(negedge clk);
      chk("t5_setup", 32'(bus0.Debug_Arb_State), 32'd1);
      bus0.CPU_Req = 1'b0;
      n_ack = 0;
      n_rd = 0;
      ack_e = -1;
      repeat (10) begin
         @(negedge clk);
         if (bus0.Read) n_rd++;
         if (bus0.CPU_Ack) begin
            n_ack++;
            ack_e = edge_cnt;
         end
      end
      chk("t5_read_cycles", 32'(n_rd), 32'd1);
      chk("t5_ack_count", 32'(n_ack), 32'd1);
      chk("t5_ack_edge", 32'(ack_e), 32'(e + 3));
      chk("t5_cpu_din", 32'(bus0.CPU_Din), 32'(mem_f(16'h0042)));

      // Randomized traffic from both ports.
      fork
         rand_port(0, 30);
         rand_port(1, 30);
      join
      repeat (8) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
